// File: rtl/mdu_controller.sv
// RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide,
// sequenced IDLE -> RUN -> DONE with a combinational stall toward the hazard logic.
module mdu_controller #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      function_3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall_request,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int unsigned W  = XLEN;
    localparam int unsigned W2 = 2 * XLEN;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic [W-1:0]    result_q, result_d;

    // Operand classification at capture time
    logic            a_signed, b_signed, sa, sb;
    logic [W-1:0]    a_mag, b_mag;
    logic            div0, ovf, special, accept, last;
    logic [W-1:0]    special_res;

    assign a_signed = !(function_3[0] && (function_3[1] || function_3[2]));
    assign b_signed = function_3[2] ? !function_3[0] : !function_3[1];
    assign sa       = a_signed && operand_a[W-1];
    assign sb       = b_signed && operand_b[W-1];
    assign a_mag    = sa ? W'(-operand_a) : operand_a;
    assign b_mag    = sb ? W'(-operand_b) : operand_b;
    assign div0     = function_3[2] && (operand_b == '0);
    assign ovf      = function_3[2] && !function_3[0] && !div0
                      && (operand_a == {1'b1, {(W-1){1'b0}}}) && (operand_b == '1);
    assign special  = div0 || ovf;
    assign special_res = div0 ? (function_3[1] ? operand_a : '1)
                              : (function_3[1] ? '0 : {1'b1, {(W-1){1'b0}}});
    assign accept   = start && !flush;
    assign last     = (cnt_q == CW'(W - 1));

    // One iteration of each datapath
    logic [W:0]      mul_sum, div_shift, div_rem;
    logic [W2-1:0]   mul_next, prod;
    logic [W-1:0]    div_quo, quo_fix, rem_fix, final_res;
    logic            div_ge;

    assign mul_sum   = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_next  = {mul_sum, acc_q[W-1:1]};
    assign div_shift = {acc_q[W-1:0], a_q[W-1]};
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_rem   = div_ge ? (div_shift - {1'b0, b_q}) : div_shift;
    assign div_quo   = {a_q[W-2:0], div_ge};
    assign prod      = neg_res_q ? W2'(-mul_next) : mul_next;
    assign quo_fix   = neg_res_q ? W'(-div_quo) : div_quo;
    assign rem_fix   = neg_rem_q ? W'(-div_rem[W-1:0]) : div_rem[W-1:0];
    assign final_res = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                               : ((op_q == 3'b000) ? prod[W-1:0] : prod[W2-1:W]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : RUN;
            RUN:     if (flush) state_d = IDLE;
                     else if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q != IDLE);
        stall_request = ((state_q == IDLE) && accept) || (state_q == RUN);
        result_valid  = (state_q == DONE);
    end

    // Datapath register updates; result only moves on a completing edge
    always_comb begin
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d      = function_3;
                    a_d       = a_mag;
                    b_d       = b_mag;
                    acc_d     = function_3[2] ? '0 : {{W{1'b0}}, b_mag};
                    cnt_d     = '0;
                    neg_res_d = sa ^ sb;
                    neg_rem_d = sa;
                    if (special) result_d = special_res;
                end
            end
            RUN: begin
                if (!flush) begin
                    cnt_d = cnt_q + CW'(1);
                    if (op_q[2]) begin
                        acc_d = {{(W-1){1'b0}}, div_rem};
                        a_d   = div_quo;
                    end else begin
                        acc_d = mul_next;
                    end
                    if (last) result_d = final_res;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: doc/mdu_controller.md
# mdu_controller

Multi-cycle sequencer and iterative datapath for RV32M multiply/divide instructions. It sits in the execute stage beside the ALU. When decode flags an instruction as an MDU operation, the execute stage pulses `start`. This block then raises `stall_request` to freeze the pipeline, runs a 32-step shift-add multiply or restoring divide, and presents a registered result for one cycle.

## Interface
Parameters:
- `XLEN`, 32, operand and result width; only 32 is supported.

Ports:
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: EX-stage instruction is an MDU operation with operands valid.
- `function_3` input 3: RV32M op select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operand_a` input 32: rs1 value, forwarded.
- `operand_b` input 32: rs2 value, forwarded.
- `flush` input 1: pipeline flush (branch, trap or mret); aborts any operation.
- `busy` output 1: state is not IDLE.
- `stall_request` output 1: combinational stall to the hazard logic.
- `result_valid` output 1: result is available this cycle (DONE state).
- `result` output 32: registered result; holds its value until the next completion.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On `start && !flush`, capture `function_3`, operand magnitudes and sign flags, and clear the 6-bit step counter.
  - Divide by zero or signed overflow goes straight to DONE. Every other operation goes to RUN.
- RUN:
  - One iteration per cycle; the counter increments each cycle.
  - After the iteration with counter == 31, go to DONE. This is exactly 32 RUN cycles.
  - The final sign fixup and result select are registered into `result` on the RUN→DONE edge.
- DONE: `result_valid`=1 for exactly one cycle, then unconditionally return to IDLE.
- Multiply:
  - 64-bit accumulator, shift-add on unsigned magnitudes.
  - MUL and MULH treat both operands as signed. MULHSU treats a as signed and b as unsigned. MULHU treats both as unsigned.
  - Negate the 64-bit product if the operand signs differ, counting only signed operands.
  - MUL returns product[31:0]; the other three return product[63:32].
- Divide:
  - Restoring algorithm on magnitudes, with a 33-bit partial remainder.
  - Signed ops negate the quotient if the operand signs differ. The remainder takes the sign of the dividend.
- Special cases, with no iteration:
  - Divide by zero: quotient 0xFFFFFFFF; remainder = `operand_a`.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000; remainder 0.
- `stall_request` = (IDLE && `start` && !`flush`) || RUN. It is 0 in DONE, so the pipeline advances and latches `result`.
- `start` is ignored in RUN and DONE.
- `flush`:
  - In any state, next state is IDLE.
  - `result_valid` is not asserted for the aborted operation, and `result` is not updated.
  - `flush` and `start` in the same IDLE cycle: flush wins and nothing is captured.
  - `flush` in DONE: `result_valid` still reads 1 that cycle, and the pipeline discards it.

## Timing
- Reset values: state IDLE, counter 0, `busy` 0, `stall_request` 0, `result_valid` 0, `result` 0x00000000.
- Reset mid-operation returns to IDLE immediately (asynchronous); no `result_valid` follows.
- Normal latency: `start` sampled at cycle 0; RUN on cycles 1–32; DONE (`result_valid`) on cycle 33.
- Special-case latency: DONE on cycle 1.
- `stall_request` is high on cycles 0–32 (cycle 0 only in the special case) and low on the DONE cycle.
- Back-to-back: the next `start` is accepted at the earliest in the IDLE cycle after DONE.

## Test plan
- MUL: `operand_a`=7, `operand_b`=0xFFFFFFFD.
  - `stall_request` high on cycles 0–32.
  - `result_valid` on cycle 33 with `result`=0xFFFFFFEB.
- MULH and MULHU: 0x80000000 × 0x80000000.
  - MULH returns 0x40000000; MULHU returns 0x40000000.
  - MULHSU with a=0xFFFFFFFF, b=2 returns 0xFFFFFFFF.
- Divide by zero: DIVU 100/0.
  - `result_valid` on cycle 1 with 0xFFFFFFFF.
  - REMU 100/0 returns 100 on cycle 1.
- Signed divide: DIV 0x80000000/0xFFFFFFFF returns 0x80000000 on cycle 1. REM -7/2 returns 0xFFFFFFFF and DIV -7/2 returns 0xFFFFFFFD, both on cycle 33.
- Flush abort: DIVU 1000/3; assert `flush` on cycle 10.
  - IDLE on cycle 11: `busy` 0, `stall_request` 0.
  - `result_valid` never asserts and `result` is unchanged.
  - A new `start` on cycle 11 completes normally on cycle 44.
- Reset mid-op and ignored start: assert `reset` on cycle 5 of a MUL; all outputs go to their reset values without waiting for a clock edge. Separately, pulse `start` during RUN; it must have no effect on `result`.
